// File: rtl/serial_input_if.sv
// Read-side bus of the UART receiver: CPU read-char handshake, FIFO status, error flags.
//   rd_req     : CPU asks for one byte (held until rd_valid)
//   rd_char    : delivered byte, held until the next delivery
//   rd_valid   : one-cycle pulse, rd_char valid in this cycle
//   fifo_count : number of buffered bytes
//   overflow   : sticky, a byte was dropped on a full FIFO
//   frame_err  : sticky, a stop bit was sampled low
//   clr_err    : clears overflow and frame_err
interface serial_input_if #(
  parameter int unsigned fifo_depth = 16
);
  localparam int unsigned cnt_w = $clog2(fifo_depth) + 1;

  logic             rd_req;
  logic [7:0]       rd_char;
  logic             rd_valid;
  logic [cnt_w-1:0] fifo_count;
  logic             overflow;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output rd_req, clr_err,
    input  rd_char, rd_valid, fifo_count, overflow, frame_err
  );

  modport slave (
    input  rd_req, clr_err,
    output rd_char, rd_valid, fifo_count, overflow, frame_err
  );
endinterface

// File: rtl/serial_input.sv
// UART 8N1 receiver with a byte FIFO, feeding the CPU read-char instruction.
//   clk, rst : system clock, asynchronous active-high reset
//   uart_rx  : serial line, idle high, asynchronous to clk
//   bus      : read handshake, FIFO count and sticky error flags (serial_input_if.slave)
module serial_input #(
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned baudrate   = 9600,
  parameter int unsigned fifo_depth = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  serial_input_if.slave bus
);

  localparam int unsigned clks_per_bit = clk_freq / baudrate;
  localparam int unsigned tmr_w        = $clog2(clks_per_bit + 1);
  localparam int unsigned ptr_w        = $clog2(fifo_depth);
  localparam int unsigned cnt_w        = ptr_w + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_prev;
  rx_state_t        state;
  logic [tmr_w-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push_pend;
  logic [7:0]       push_data;
  logic             frame_err_q;

  logic [7:0]       mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic [7:0]       rd_char_q;
  logic             rd_valid_q;
  logic             overflow_q;

  logic tmr_done_c;
  logic pop_c;
  logic full_c;
  logic push_ok_c;

  assign rx_s       = rx_sync[1];
  assign tmr_done_c = (timer == tmr_w'(1));
  assign full_c     = (count == cnt_w'(fifo_depth));
  assign pop_c      = bus.rd_req && (count != '0) && !rd_valid_q;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign push_ok_c  = push_pend && (!full_c || pop_c);

  // Two-flop synchronizer plus previous-value flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  // RX FSM: timer counts down to 1, the sample is taken on that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_pend   <= 1'b0;
      push_data   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      // Clear first so a same-cycle framing error below takes priority.
      if (bus.clr_err) frame_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            timer <= tmr_w'(clks_per_bit / 2);
            state <= S_START;
          end
        end
        S_START: begin
          if (tmr_done_c) begin
            if (!rx_s) begin
              timer   <= tmr_w'(clks_per_bit);
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - tmr_w'(1);
          end
        end
        S_DATA: begin
          if (tmr_done_c) begin
            shift[bit_idx] <= rx_s;
            timer          <= tmr_w'(clks_per_bit);
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - tmr_w'(1);
          end
        end
        S_STOP: begin
          if (tmr_done_c) begin
            if (rx_s) begin
              push_pend <= 1'b1;
              push_data <= shift;
              state     <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            timer <= timer - tmr_w'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, count, read handshake and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_char_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_c;
      if (pop_c) begin
        rd_char_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ptr_w'(1);
      end
      if (push_ok_c) wr_ptr <= wr_ptr + ptr_w'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
      if (bus.clr_err) overflow_q <= 1'b0;
      if (push_pend && full_c && !pop_c) overflow_q <= 1'b1;
    end
  end

  assign bus.rd_char    = rd_char_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;

endmodule
